// File: rtl/game_timer_ctrl_if.sv
// Control/status bundle between the game-state logic and the elapsed-time
// sequencer. The game FSM is the master (issues pulses and reads the count).
// The timer is the slave.
interface game_timer_ctrl_if #(
    parameter int unsigned SEC_W = 10
);
    logic             start;
    logic             pause;
    logic             game_over;
    logic             clear;
    logic [SEC_W-1:0] seconds;
    logic             sec_tick;
    logic             running;
    logic             saturated;

    modport master (
        output start, pause, game_over, clear,
        input  seconds, sec_tick, running, saturated
    );

    modport slave (
        input  start, pause, game_over, clear,
        output seconds, sec_tick, running, saturated
    );
endinterface

// File: rtl/game_timer_ctrl.sv
// Elapsed-time sequencer for the in-game timer display.
// The module divides clk into a 1 s prescaler wrap and keeps a saturating
// seconds count. An IDLE/RUN/PAUSED/DONE state machine gates the count.
// All outputs are registered. The next value of every register is computed
// in one combinational process, so a clear, a wrap and a state change on the
// same edge resolve in a single place.
module game_timer_ctrl #(
    parameter int unsigned CLK_FREQ_HZ = 65_000_000,
    parameter int unsigned MAX_SEC     = 999,
    parameter int unsigned SEC_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    game_timer_ctrl_if.slave  bus
);
    localparam int unsigned     PW         = $clog2(CLK_FREQ_HZ);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_FREQ_HZ - 1);
    localparam logic [SEC_W-1:0] SEC_MAX   = SEC_W'(MAX_SEC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [PW-1:0]    r_presc,    w_presc_nxt;
    logic [SEC_W-1:0] r_seconds,  w_seconds_nxt;
    logic             r_tick,     w_tick_nxt;
    logic             r_running,  w_running_nxt;
    logic             r_sat,      w_sat_nxt;
    logic [SEC_W-1:0] w_sec_inc;
    logic             w_wrap;
    logic             w_sat_hit;

    assign w_sec_inc = r_seconds + 1'b1;
    assign w_wrap    = (r_state == S_RUN) && (r_presc == PRESC_LAST);
    assign w_sat_hit = w_wrap && (w_sec_inc == SEC_MAX);

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_seconds <= '0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_seconds <= w_seconds_nxt;
            r_tick    <= w_tick_nxt;
            r_running <= w_running_nxt;
            r_sat     <= w_sat_nxt;
        end
    end

    // Next-state and next-count logic. Priority: clear > game_over > start > pause.
    // A wrap always ticks on its edge, even when the same edge leaves RUN.
    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_seconds_nxt = r_seconds;
        w_tick_nxt    = 1'b0;
        w_sat_nxt     = r_sat;

        if (bus.clear) begin
            w_state_nxt   = S_IDLE;
            w_presc_nxt   = '0;
            w_seconds_nxt = '0;
            w_sat_nxt     = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_presc_nxt   = '0;
                    w_seconds_nxt = '0;
                    if (bus.start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_wrap) begin
                        w_presc_nxt = '0;
                        if (r_seconds != SEC_MAX) begin
                            w_seconds_nxt = w_sec_inc;
                        end
                        w_tick_nxt = 1'b1;
                    end else begin
                        w_presc_nxt = r_presc + 1'b1;
                    end
                    if (w_sat_hit) begin
                        w_sat_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (bus.game_over) begin
                        w_state_nxt = S_DONE;
                    end else if (bus.pause) begin
                        w_state_nxt = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (bus.game_over) begin
                        w_state_nxt = S_DONE;
                    end else if (bus.start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_presc_nxt   = '0;
                    w_seconds_nxt = '0;
                    w_sat_nxt     = 1'b0;
                end
            endcase
        end

        w_running_nxt = (w_state_nxt == S_RUN);
    end

    assign bus.seconds   = r_seconds;
    assign bus.sec_tick  = r_tick;
    assign bus.running   = r_running;
    assign bus.saturated = r_sat;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with CLK_FREQ_HZ=4, MAX_SEC=5, SEC_W=3.
module tb_game_timer_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;
    int   ticks;

    game_timer_ctrl_if #(.SEC_W(3)) bus ();

    game_timer_ctrl #(
        .CLK_FREQ_HZ (4),
        .MAX_SEC     (5),
        .SEC_W       (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs n cycles and returns the number of sec_tick pulses observed.
    task automatic run_count(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.sec_tick) cnt++;
        end
    endtask

    task automatic pulse(input logic st, input logic pa, input logic go, input logic cl);
        bus.start     = st;
        bus.pause     = pa;
        bus.game_over = go;
        bus.clear     = cl;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        bus.game_over = 1'b0;
        bus.clear     = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.pause = 1'b0; bus.game_over = 1'b0; bus.clear = 1'b0;
        step(2);
        chk("rst_seconds",   32'(bus.seconds),   0);
        chk("rst_tick",      32'(bus.sec_tick),  0);
        chk("rst_running",   32'(bus.running),   0);
        chk("rst_saturated", 32'(bus.saturated), 0);
        rst_n = 1'b1;
        step(3);
        chk("idle_running", 32'(bus.running), 0);

        // Basic run: ticks on edges 4, 8, 12 after the start edge.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("run_running", 32'(bus.running), 1);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk($sformatf("run_tick_e%0d", k), 32'(bus.sec_tick), (k % 4 == 0) ? 1 : 0);
            chk($sformatf("run_sec_e%0d", k),  32'(bus.seconds),  32'(k / 4));
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_seconds", 32'(bus.seconds), 0);
        chk("clr_running", 32'(bus.running), 0);

        // Pause/resume keeps the prescaler: 6 RUN cycles, pause, resume.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(5);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_running", 32'(bus.running), 0);
        chk("pause_seconds", 32'(bus.seconds), 1);
        run_count(10, ticks);
        chk("pause_ticks", 32'(ticks), 0);
        chk("pause_hold_seconds", 32'(bus.seconds), 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("resume_running", 32'(bus.running), 1);
        step(1);
        chk("resume_tick_e1", 32'(bus.sec_tick), 0);
        step(1);
        chk("resume_tick_e2", 32'(bus.sec_tick), 1);
        chk("resume_seconds", 32'(bus.seconds), 2);

        // Saturation at 5 four-cycle seconds later: seconds 3,4,5.
        step(12);
        chk("sat_seconds", 32'(bus.seconds),   5);
        chk("sat_tick",    32'(bus.sec_tick),  1);
        chk("sat_flag",    32'(bus.saturated), 1);
        chk("sat_running", 32'(bus.running),   0);
        step(1);
        chk("sat_tick_after", 32'(bus.sec_tick), 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        run_count(8, ticks);
        chk("done_ticks",    32'(ticks),         0);
        chk("done_seconds",  32'(bus.seconds),   5);
        chk("done_running",  32'(bus.running),   0);
        chk("done_sat",      32'(bus.saturated), 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sat_clr_seconds", 32'(bus.seconds),   0);
        chk("sat_clr_flag",    32'(bus.saturated), 0);

        // game_over beats start while PAUSED; clear beats start.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        chk("go_running", 32'(bus.running), 0);
        run_count(12, ticks);
        chk("go_ticks",   32'(ticks),       0);
        chk("go_seconds", 32'(bus.seconds), 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        chk("clrst_running", 32'(bus.running), 0);
        chk("clrst_seconds", 32'(bus.seconds), 0);
        run_count(6, ticks);
        chk("clrst_idle_running", 32'(bus.running), 0);
        chk("clrst_idle_ticks",   32'(ticks),       0);

        // pause on the wrap edge: tick and increment still happen.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(3);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pwrap_tick",    32'(bus.sec_tick), 1);
        chk("pwrap_seconds", 32'(bus.seconds),  1);
        chk("pwrap_running", 32'(bus.running),  0);
        step(1);
        chk("pwrap_tick_after", 32'(bus.sec_tick), 0);
        run_count(8, ticks);
        chk("pwrap_ticks",     32'(ticks),       0);
        chk("pwrap_seconds_h", 32'(bus.seconds), 1);

        // Asynchronous reset mid-run with seconds=2.
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(8);
        chk("pre_rst_seconds", 32'(bus.seconds), 2);
        chk("pre_rst_running", 32'(bus.running), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_seconds",   32'(bus.seconds),   0);
        chk("arst_tick",      32'(bus.sec_tick),  0);
        chk("arst_running",   32'(bus.running),   0);
        chk("arst_saturated", 32'(bus.saturated), 0);
        step(2);
        rst_n = 1'b1;
        run_count(6, ticks);
        chk("post_rst_running", 32'(bus.running), 0);
        chk("post_rst_seconds", 32'(bus.seconds), 0);
        chk("post_rst_ticks",   32'(ticks),       0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(3);
        chk("post_rst_tick_e3", 32'(bus.sec_tick), 0);
        step(1);
        chk("post_rst_tick_e4", 32'(bus.sec_tick), 1);
        chk("post_rst_sec_e4",  32'(bus.seconds),  1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
